// File: rtl/mod_counter_chain.sv
// Modulo-N up/down time-base counter with clamped preset load, cascade carry
// and registered BCD digits for the display mux.
module mod_counter_chain #(
  parameter int MODULUS   = 60,
  parameter int WIDTH     = 7,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             tc,
  output logic             carry,
  output logic             load_err
);

  // Digit arithmetic runs at least 8 bits wide so the constant 10 never truncates
  // for small WIDTH values.
  localparam int               EW        = (WIDTH > 8) ? WIDTH : 8;
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
  localparam logic [3:0]       RST_TENS  = 4'(RESET_VAL / 10);
  localparam logic [3:0]       RST_ONES  = 4'(RESET_VAL % 10);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("mod_counter_chain: MODULUS=%0d outside 2..100", MODULUS);
  end
  if (MODULUS > 2**WIDTH) begin : g_bad_width
    $error("mod_counter_chain: MODULUS=%0d does not fit WIDTH=%0d", MODULUS, WIDTH);
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("mod_counter_chain: RESET_VAL=%0d outside 0..MODULUS-1", RESET_VAL);
  end

  logic             load_oor;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] next_count;
  logic [EW-1:0]    next_ext;
  logic [3:0]       next_tens;
  logic [3:0]       next_ones;

  assign load_oor     = {1'b0, load_val} >= MOD_EXT;
  assign load_clamped = load_oor ? MAX_VAL : load_val;
  assign at_max       = (count == MAX_VAL);
  assign at_zero      = (count == '0);

  assign tc    = up ? at_max : at_zero;
  // Carry fires in the cycle whose edge wraps this stage, so the next stage
  // steps on that same edge.
  assign carry = en & tc & ~load & reset_n;

  // NOTE: next_count gets a default before any branch so this block can never
  // infer a latch when neither load nor en is asserted.
  always_comb begin
    next_count = count;
    if (load) begin
      next_count = load_clamped;
    end else if (en) begin
      if (up) next_count = at_max  ? '0      : count + WIDTH'(1);
      else    next_count = at_zero ? MAX_VAL : count - WIDTH'(1);
    end
  end

  // Digits come from the next value so they land on the same edge as count.
  assign next_ext  = EW'(next_count);
  assign next_tens = 4'(next_ext / EW'(10));
  assign next_ones = 4'(next_ext % EW'(10));

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= RST_COUNT;
      bcd_tens <= RST_TENS;
      bcd_ones <= RST_ONES;
      load_err <= 1'b0;
    end else begin
      count    <= next_count;
      bcd_tens <= next_tens;
      bcd_ones <= next_ones;
      if (load) load_err <= load_oor;
    end
  end

endmodule

// File: tb/tb_mod_counter_chain.sv
// Scoreboard bench for mod_counter_chain: a driver pushes hand-computed
// expectations, a monitor pops and compares them each cycle.
module tb_mod_counter_chain;

  logic       clk = 1'b0;
  logic       reset_n, en, up, load;
  logic [6:0] load_val;
  logic [6:0] count;
  logic [3:0] bcd_tens, bcd_ones;
  logic       tc, carry, load_err;

  // Second stage for the cascade scenario: its enable is the first stage's carry.
  logic       min_load;
  logic [6:0] min_load_val;
  logic [6:0] min_count;
  logic [3:0] min_tens, min_ones;
  logic       min_tc, min_carry, min_load_err;

  always #5 clk = ~clk;

  mod_counter_chain #(.MODULUS(60), .WIDTH(7), .RESET_VAL(0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .tc(tc), .carry(carry),
    .load_err(load_err)
  );

  mod_counter_chain #(.MODULUS(60), .WIDTH(7), .RESET_VAL(0)) u_min (
    .clk(clk), .reset_n(reset_n), .en(carry), .up(1'b1), .load(min_load),
    .load_val(min_load_val), .count(min_count), .bcd_tens(min_tens), .bcd_ones(min_ones),
    .tc(min_tc), .carry(min_carry), .load_err(min_load_err)
  );

  typedef struct {
    string      name;
    logic       carry;
    logic [6:0] count;
    logic       err;
    bit         chk_min;
    logic       min_carry;
    logic [6:0] min_count;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %0d, expected %0d", name, act, req);
    else passed++;
  endtask

  // Monitor: carry is sampled late in the cycle with inputs settled,
  // registered outputs just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.name, ".carry"}, 32'(carry), 32'(e.carry));
        if (e.chk_min) check({e.name, ".min_carry"}, 32'(min_carry), 32'(e.min_carry));
        @(posedge clk);
        #1;
        check({e.name, ".count"},    32'(count),    32'(e.count));
        check({e.name, ".tens"},     32'(bcd_tens), 32'(e.count / 10));
        check({e.name, ".ones"},     32'(bcd_ones), 32'(e.count % 10));
        check({e.name, ".load_err"}, 32'(load_err), 32'(e.err));
        if (e.chk_min) check({e.name, ".min_count"}, 32'(min_count), 32'(e.min_count));
      end
    end
  end

  // One cycle of stimulus plus the expected carry in that cycle and the
  // expected state after its edge.
  task automatic cyc(input string name, input logic rn, input logic e_in, input logic u_in,
                     input logic l_in, input logic [6:0] lv, input logic exp_carry,
                     input logic [6:0] exp_count, input logic exp_err,
                     input bit chk_min = 1'b0, input logic ml = 1'b0,
                     input logic [6:0] mlv = 7'd0, input logic exp_min_carry = 1'b0,
                     input logic [6:0] exp_min_count = 7'd0);
    exp_t e;
    @(negedge clk);
    reset_n      = rn;
    en           = e_in;
    up           = u_in;
    load         = l_in;
    load_val     = lv;
    min_load     = ml;
    min_load_val = mlv;
    e.name      = name;
    e.carry     = exp_carry;
    e.count     = exp_count;
    e.err       = exp_err;
    e.chk_min   = chk_min;
    e.min_carry = exp_min_carry;
    e.min_count = exp_min_count;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b1; load_val = 7'd42;
    min_load = 1'b0; min_load_val = 7'd0;

    // Reset overrides load and en; carry stays low.
    cyc("rst_load",    0, 0, 1, 1, 42, 0, 0, 0, 1'b1, 0, 0, 0, 0);
    cyc("rst_load_en", 0, 1, 0, 1, 42, 0, 0, 0, 1'b1, 0, 0, 0, 0);

    // Full upward lap plus one: carry only while count is 59.
    for (int i = 0; i <= 60; i++)
      cyc($sformatf("up_%0d", i), 1, 1, 1, 0, 0, (i % 60) == 59, 7'((i + 1) % 60), 0);

    // Down from 1: 0, wrap to 59 with carry, then 58, 57.
    cyc("dn_1",  1, 1, 0, 0, 0, 0, 0,  0);
    cyc("dn_0",  1, 1, 0, 0, 0, 1, 59, 0);
    cyc("dn_59", 1, 1, 0, 0, 0, 0, 58, 0);
    cyc("dn_58", 1, 1, 0, 0, 0, 0, 57, 0);

    // Out-of-range loads clamp and set the sticky flag; valid loads clear it.
    cyc("ld_75", 1, 0, 1, 1, 75, 0, 59, 1);
    cyc("hold_err", 1, 0, 1, 0, 0, 0, 59, 1);
    cyc("ld_12", 1, 0, 1, 1, 12, 0, 12, 0);
    cyc("ld_60", 1, 0, 1, 1, 60, 0, 59, 1);
    cyc("ld_59", 1, 0, 1, 1, 59, 0, 59, 0);

    // Load wins over en at terminal count; no carry.
    cyc("ld_en_30", 1, 1, 1, 1, 30, 0, 30, 0);

    // en toggling 1,0,1: hold in the middle cycle.
    cyc("tog_en1", 1, 1, 1, 0, 0, 0, 31, 0);
    cyc("tog_en0", 1, 0, 1, 0, 0, 0, 31, 0);
    cyc("tog_en2", 1, 1, 1, 0, 0, 0, 32, 0);

    // Direction change while enabled.
    cyc("dir_dn", 1, 1, 0, 0, 0, 0, 31, 0);
    cyc("dir_up", 1, 1, 1, 0, 0, 0, 32, 0);

    // Cascade: both stages at 59 wrap together, min.carry high in that cycle.
    cyc("casc_ld",   1, 0, 1, 1, 59, 0, 59, 0, 1'b1, 1, 59, 0, 59);
    cyc("casc_wrap", 1, 1, 1, 0, 0,  1, 0,  0, 1'b1, 0, 0,  1, 0);
    cyc("casc_next", 1, 1, 1, 0, 0,  0, 1,  0, 1'b1, 0, 0,  0, 0);

    // Reset mid-count at 37.
    cyc("ld_37",     1, 0, 1, 1, 37, 0, 37, 0);
    cyc("rst_mid",   0, 1, 1, 0, 0,  0, 0,  0);
    cyc("post_rst",  1, 1, 1, 0, 0,  0, 1,  0);

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
